// File: rtl/led_pattern_pkg.sv
// Shared types and start-state constants for the LED pattern engine.
//   led_mode_e : pattern select (COUNT, SCAN, BREATHE, FREEZE)
//   DIR_UP/DIR_DOWN : direction encoding for scan and breathe ramps
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_FREEZE  = 2'd3
    } led_mode_e;

    localparam logic      DIR_UP     = 1'b0;
    localparam logic      DIR_DOWN   = 1'b1;
    localparam led_mode_e RESET_MODE = MODE_COUNT;

endpackage

// File: rtl/led_prescaler.sv
// Programmable step prescaler: counts enabled cycles and flags a step once
// the count reaches the divider, then restarts from zero.
//   clk, rst : clock, synchronous active-high reset
//   en_i     : count enable
//   clr_i    : restart the count (pattern reinitialisation)
//   div_i    : step period minus 1
//   step_o   : combinational step strobe for the current cycle
module led_prescaler #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             step_o
);

    logic [DIV_W-1:0] pcnt_q;
    logic [DIV_W-1:0] pcnt_d;

    // >= rather than == so that shrinking the divider below the count steps at once.
    assign step_o = en_i && (pcnt_q >= div_i);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr_i) begin
            pcnt_d = '0;
        end else if (step_o) begin
            pcnt_d = '0;
        end else if (en_i) begin
            pcnt_d = pcnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled step tick driving a binary counter, a
// bouncing one-hot scan, a PWM breathe ramp, or a frozen display.
//   clk, rst : clock, synchronous active-high reset
//   en_i     : run enable; all state holds while low
//   mode_i   : pattern select
//   div_i    : step period minus 1 in clk cycles
//   leds_o   : registered LED drive
//   tick_o   : registered one-cycle pulse per pattern step
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned DIV_W    = 24,
    parameter int unsigned PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  led_mode_e           mode_i,
    input  logic [DIV_W-1:0]    div_i,
    output logic [NUM_LEDS-1:0] leds_o,
    output logic                tick_o
);

    localparam logic [PWM_W-1:0]    DUTY_MAX = '1;
    localparam logic [NUM_LEDS-1:0] POS_INIT = NUM_LEDS'(1);

    led_mode_e           mode_q,     mode_d;
    logic [NUM_LEDS-1:0] cnt_q,      cnt_d;
    logic [NUM_LEDS-1:0] pos_q,      pos_d;
    logic                dir_q,      dir_d;
    logic [PWM_W-1:0]    duty_q,     duty_d;
    logic                duty_dir_q, duty_dir_d;
    logic [PWM_W-1:0]    phase_q,    phase_d;
    logic [NUM_LEDS-1:0] leds_q,     leds_d;
    logic                tick_q,     tick_d;

    logic                step_c;
    logic                reinit_c;

    // Any change of requested mode restarts every pattern from its start state.
    assign reinit_c = (mode_i != mode_q);

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_i),
        .clr_i  (reinit_c),
        .div_i  (div_i),
        .step_o (step_c)
    );

    // Next-state and output logic for all pattern modes.
    always_comb begin
        mode_d     = mode_i;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        dir_d      = dir_q;
        duty_d     = duty_q;
        duty_dir_d = duty_dir_q;
        phase_d    = phase_q;
        leds_d     = leds_q;
        tick_d     = 1'b0;

        if (reinit_c) begin
            // Outputs blank for the restart cycle; FREEZE therefore shows all-off.
            cnt_d      = '0;
            pos_d      = POS_INIT;
            dir_d      = DIR_UP;
            duty_d     = '0;
            duty_dir_d = DIR_UP;
            phase_d    = '0;
            leds_d     = '0;
        end else if (en_i) begin
            case (mode_q)
                MODE_COUNT: begin
                    leds_d = cnt_q;
                    tick_d = step_c;
                    if (step_c) begin
                        cnt_d = cnt_q + NUM_LEDS'(1);
                    end
                end
                MODE_SCAN: begin
                    leds_d = pos_q;
                    tick_d = step_c;
                    // A single LED has nowhere to move.
                    if (step_c && (NUM_LEDS > 1)) begin
                        if (dir_q == DIR_UP) begin
                            if (pos_q[NUM_LEDS-1]) begin
                                pos_d = pos_q >> 1;
                                dir_d = DIR_DOWN;
                            end else begin
                                pos_d = pos_q << 1;
                            end
                        end else begin
                            if (pos_q[0]) begin
                                pos_d = pos_q << 1;
                                dir_d = DIR_UP;
                            end else begin
                                pos_d = pos_q >> 1;
                            end
                        end
                    end
                end
                MODE_BREATHE: begin
                    phase_d = phase_q + PWM_W'(1);
                    leds_d  = {NUM_LEDS{phase_q < duty_q}};
                    tick_d  = step_c;
                    if (step_c) begin
                        if (duty_dir_q == DIR_UP) begin
                            if (duty_q == DUTY_MAX) begin
                                duty_d     = duty_q - PWM_W'(1);
                                duty_dir_d = DIR_DOWN;
                            end else begin
                                duty_d = duty_q + PWM_W'(1);
                            end
                        end else begin
                            if (duty_q == '0) begin
                                duty_d     = duty_q + PWM_W'(1);
                                duty_dir_d = DIR_UP;
                            end else begin
                                duty_d = duty_q - PWM_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    // FREEZE: display and pattern state hold, no tick.
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= RESET_MODE;
            cnt_q      <= '0;
            pos_q      <= POS_INIT;
            dir_q      <= DIR_UP;
            duty_q     <= '0;
            duty_dir_q <= DIR_UP;
            phase_q    <= '0;
            leds_q     <= '0;
            tick_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            dir_q      <= dir_d;
            duty_q     <= duty_d;
            duty_dir_q <= duty_dir_d;
            phase_q    <= phase_d;
            leds_q     <= leds_d;
            tick_q     <= tick_d;
        end
    end

    assign leds_o = leds_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (4 LEDs, 16-bit divider, 8-bit PWM).
// The reference model tracks steps taken since the last restart and derives
// the display from closed-form pattern functions.
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    logic       clk;
    logic       rst;
    logic       en_i;
    led_mode_e  mode_i;
    logic [15:0] div_i;
    logic [3:0] leds_o;
    logic       tick_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    led_mode_e  m_mode;
    int         m_pcnt;
    int         m_k;
    int         m_phase;
    logic [3:0] m_leds;
    logic       m_tick;

    led_pattern_gen #(
        .NUM_LEDS (4),
        .DIV_W    (16),
        .PWM_W    (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_i),
        .mode_i (mode_i),
        .div_i  (div_i),
        .leds_o (leds_o),
        .tick_o (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Triangle wave 0..m..0 of period 2m.
    function automatic int tri_wave(input int k, input int m);
        int r;
        r = k % (2 * m);
        return (r <= m) ? r : (2 * m - r);
    endfunction

    function automatic logic [3:0] pat(input led_mode_e md, input int k, input int ph);
        case (md)
            MODE_COUNT:   return 4'(k % 16);
            MODE_SCAN:    return 4'(1 << tri_wave(k, 3));
            MODE_BREATHE: return (ph < tri_wave(k, 255)) ? 4'hF : 4'h0;
            default:      return 4'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic stp;
        if (rst) begin
            m_mode = MODE_COUNT; m_pcnt = 0; m_k = 0; m_phase = 0;
            m_leds = 4'h0; m_tick = 1'b0;
        end else if (mode_i != m_mode) begin
            m_mode = mode_i; m_pcnt = 0; m_k = 0; m_phase = 0;
            m_leds = 4'h0; m_tick = 1'b0;
        end else if (!en_i) begin
            m_tick = 1'b0;
        end else begin
            stp = (m_pcnt >= int'(div_i));
            if (m_mode != MODE_FREEZE) m_leds = pat(m_mode, m_k, m_phase);
            m_tick = stp && (m_mode != MODE_FREEZE);
            if (m_tick) m_k++;
            m_pcnt = stp ? 0 : m_pcnt + 1;
            if (m_mode == MODE_BREATHE) m_phase = (m_phase + 1) % 256;
        end
    endtask

    // Drive one cycle, advance the model at the edge, compare just after it.
    task automatic cycle(input logic r, input logic e, input led_mode_e md, input int dv);
        rst    = r;
        en_i   = e;
        mode_i = md;
        div_i  = 16'(dv);
        @(posedge clk);
        model_step();
        #1;
        chk("leds", 32'(leds_o), 32'(m_leds));
        chk("tick", 32'(tick_o), 32'(m_tick));
    endtask

    initial begin
        logic [3:0] scan_seq [8];
        logic [3:0] held;
        int         found;
        int         lat;
        int         ones;
        led_mode_e  rmode;

        scan_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        rst = 1'b1; en_i = 1'b0; mode_i = MODE_COUNT; div_i = 16'd0;
        m_mode = MODE_COUNT; m_pcnt = 0; m_k = 0; m_phase = 0; m_leds = 4'h0; m_tick = 1'b0;

        // Reset held for three cycles, then free-running count with div 0.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, MODE_COUNT, 0);
            chk("reset_leds", 32'(leds_o), 32'h0);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, MODE_COUNT, 0);

        // COUNT wrap with div 2: display goes F then 0.
        found = 0;
        for (int i = 0; i < 120 && found == 0; i++) begin
            cycle(1'b0, 1'b1, MODE_COUNT, 2);
            if (leds_o == 4'hF) found = 1;
        end
        chk("wrap_reach_f", 32'(found), 32'd1);
        for (int i = 0; i < 5 && leds_o == 4'hF; i++) cycle(1'b0, 1'b1, MODE_COUNT, 2);
        chk("count_wrap_0", 32'(leds_o), 32'h0);

        // SCAN bounce with div 0.
        cycle(1'b0, 1'b1, MODE_SCAN, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, MODE_SCAN, 0);
            chk("scan_seq", 32'(leds_o), 32'(scan_seq[i]));
        end

        // Mode change mid-step: COUNT at cnt 5, pcnt 3, div 9, then SCAN.
        cycle(1'b0, 1'b1, MODE_COUNT, 9);
        for (int i = 0; i < 200 && !(m_k == 5 && m_pcnt == 3); i++)
            cycle(1'b0, 1'b1, MODE_COUNT, 9);
        chk("mid_step_setup", 32'(m_k * 16 + m_pcnt), 32'(5 * 16 + 3));
        cycle(1'b0, 1'b1, MODE_SCAN, 9);
        lat = 0;
        for (int n = 1; n <= 50 && lat == 0; n++) begin
            cycle(1'b0, 1'b1, MODE_SCAN, 9);
            if (tick_o) lat = n;
        end
        chk("first_tick_latency", 32'(lat), 32'd10);

        // Enable low: display and tick frozen.
        held = m_leds;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, MODE_SCAN, 9);
        chk("en_low_hold", 32'(leds_o), 32'(held));
        chk("en_low_tick", 32'(tick_o), 32'd0);

        // Divider drop below running count steps on the next enabled cycle.
        for (int i = 0; i < 30 && m_pcnt != 7; i++) cycle(1'b0, 1'b1, MODE_SCAN, 9);
        chk("pcnt_at_7", 32'(m_pcnt), 32'd7);
        cycle(1'b0, 1'b1, MODE_SCAN, 3);
        chk("div_drop_tick", 32'(tick_o), 32'd1);

        // BREATHE: ramp duty to 64, stop stepping, count lit cycles over a phase period.
        cycle(1'b0, 1'b1, MODE_BREATHE, 0);
        for (int i = 0; i < 200 && m_k < 64; i++) cycle(1'b0, 1'b1, MODE_BREATHE, 0);
        cycle(1'b0, 1'b1, MODE_BREATHE, 60000);
        cycle(1'b0, 1'b1, MODE_BREATHE, 60000);
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 1'b1, MODE_BREATHE, 60000);
            if (leds_o === 4'hF) ones++;
        end
        chk("breathe_duty64", 32'(ones), 32'd64);

        // Duty ramps past the top and back through zero.
        for (int i = 0; i < 520; i++) cycle(1'b0, 1'b1, MODE_BREATHE, 0);

        // FREEZE entered from BREATHE shows the blank start state.
        cycle(1'b0, 1'b1, MODE_FREEZE, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, MODE_FREEZE, 0);
        chk("freeze_leds", 32'(leds_o), 32'h0);

        // Randomized mix of modes, enables, dividers and occasional reset.
        rmode = MODE_FREEZE;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) rmode = led_mode_e'($urandom_range(0, 3));
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), rmode,
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine. It is the successor to the fixed 8-LED blinky core in the SoC examples. A programmable prescaler produces a step tick, and a selectable mode engine drives an N-bit LED bus. The modes are binary count, bouncing scan, PWM breathe and freeze. It sits between the SoC control registers (mode, divider, enable) and the board LED pins.

## Interface

- `NUM_LEDS`, default 8: LED bus width, 1..32.
- `DIV_W`, default 24: prescaler divider width.
- `PWM_W`, default 8: breathe duty/phase width.

Ports:

- `clk`  in  1: system clock, sole clock domain.
- `rst`  in  1: synchronous reset, active-high.
- `en_i`  in  1: run enable. When 0, all internal state freezes.
- `mode_i`  in  2: pattern select, of type `led_mode_e`.
- `div_i`  in  DIV_W: step period minus 1, in clk cycles.
- `leds_o`  out  NUM_LEDS: LED drive, registered.
- `tick_o`  out  1: one-cycle pulse marking a pattern step, registered.

## Operation

- **Modes** (`led_mode_e`): COUNT=0, SCAN=1, BREATHE=2, FREEZE=3.
- **Prescaler**
  - `pcnt` counts up each cycle while `en_i`=1.
  - step = `en_i` && (`pcnt` >= `div_i`). On a step, `pcnt` is cleared to 0.
  - The >= compare means lowering `div_i` below `pcnt` forces a step on the next cycle. `div_i`=0 steps every enabled cycle.
- **COUNT**
  - Register `cnt` (NUM_LEDS bits) increments on each step and wraps from all-ones to 0.
  - `leds_o` = `cnt`.
- **SCAN**
  - One-hot position `pos` plus direction bit `dir` (0 = up).
  - On each step, `pos` moves one bit in direction `dir`. It reverses at bit NUM_LEDS-1 and at bit 0, so end bits are lit for exactly one step.
  - NUM_LEDS=4 sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - NUM_LEDS=1: stays at 1.
- **BREATHE**
  - `phase` (PWM_W bits) increments every enabled cycle and wraps.
  - `duty` (PWM_W bits) moves by 1 per step. It ramps up to all-ones, reverses, ramps down to 0, reverses.
  - All LEDs = (`phase` < `duty`). `duty`=0 gives fully off.
- **FREEZE**: pattern state and `leds_o` hold. The prescaler still runs, but `tick_o` stays 0.
- **Mode change**
  - `mode_q` registers `mode_i`.
  - In the cycle after `mode_i` != `mode_q`: `mode_q` updates, and all pattern state is reinitialised (`cnt`=0, `pos`=bit 0, `dir`=up, `duty`=0, `phase`=0, `pcnt`=0).
  - Reinitialisation takes priority over a coincident step.
  - A change to FREEZE also reinitialises, so FREEZE entered from any mode shows the start state.
- **Enable low**
  - Counters, pattern state, `phase` and `leds_o` hold their values. `tick_o`=0.
  - Mode changes are still captured and reinitialise state.

## Timing

- **Reset** (while `rst` is high): `leds_o`=0, `tick_o`=0, `pcnt`=0, `cnt`=0, `pos`=bit 0, `dir`=up, `duty`=0, `phase`=0, `mode_q`=COUNT.
- **`leds_o`**: registered function of (`mode_q`, pattern state). It lags the state by 1 cycle.
  - First cycle after reset in SCAN gives `leds_o`=1 after the mode-change cycle plus 1.
- **`tick_o`**: asserted in the cycle after a step edge, i.e. coincident with the state register change. The new pattern appears on `leds_o` one cycle later.
- **Step period**: `div_i`+1 enabled cycles.
- **Reset mid-operation**: all state returns to reset values on that edge. No partial step.

## Structure

- Package `led_pattern_pkg`: `led_mode_e` enum and the reinit constants.
- Sub-module `led_prescaler`
  - Parameter DIV_W.
  - Ports: `clk`, `rst`, `en_i`, `clr_i`, `div_i`, `step_o`.
  - `clr_i` is driven by the mode-change reinit.
- Top level: mode register, per-mode state, output mux and registers.

## Test plan

1. **Reset**: hold `rst` 3 cycles, release with `mode_i`=COUNT, `div_i`=0, `en_i`=1 → `leds_o`=0 during reset; afterwards `leds_o` = 0, 1, 2, 3… incrementing each cycle; `tick_o` high every cycle.
2. **COUNT wrap**: NUM_LEDS=4, `div_i`=2 → `tick_o` every 3rd cycle; `leds_o` goes 15 then 0.
3. **SCAN bounce**: NUM_LEDS=4, `div_i`=0 → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; no repeated end value.
4. **BREATHE duty**: PWM_W=8, stop stepping at `duty`=64 (`div_i` large) → over 256 cycles exactly 64 cycles with `leds_o`=all ones; `duty` reverses after 255.
5. **Mode change mid-step**: COUNT at `cnt`=5, `pcnt`=3, `div_i`=9; switch to SCAN → next cycle state reinitialised, `pcnt`=0; first `tick_o` 10 cycles later.
6. **Enable and divider**: deassert `en_i` for 20 cycles → `leds_o` and `tick_o`=0 frozen. Then, with `pcnt`=7, drop `div_i` from 9 to 3 → step on the next enabled cycle.
